// File: rtl/time_adjust_ctrl_pkg.sv
// Shared types and constants for the time-adjust command generator.
package time_adjust_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic FIELD_MIN = 1'b0;
    localparam logic FIELD_HR  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Button/strobe inputs and counter command outputs of the time-adjust controller.
interface time_adjust_ctrl_if;
    logic tick;
    logic minute_tick;
    logic adj_mode;
    logic btn_up;
    logic btn_down;
    logic btn_sel;
    logic min_carry;
    logic min_en;
    logic min_updown;
    logic hr_en;
    logic hr_updown;
    logic field;

    modport master (
        input  tick, minute_tick, adj_mode, btn_up, btn_down, btn_sel, min_carry,
        output min_en, min_updown, hr_en, hr_updown, field
    );

    modport slave (
        output tick, minute_tick, adj_mode, btn_up, btn_down, btn_sel, min_carry,
        input  min_en, min_updown, hr_en, hr_updown, field
    );
endinterface

// File: rtl/time_adjust_ctrl_edge_pulse.sv
// Rising-edge detector with a history register; stays quiet on the first cycle
// after reset so a level already high at reset release is not seen as an edge.
module time_adjust_ctrl_edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic prev_q;
    logic armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= din;
            armed_q <= 1'b1;
        end
    end

    assign rise = armed_q & din & ~prev_q;
endmodule

// File: rtl/time_adjust_ctrl.sv
// Turns buttons into counter enables with press-and-hold auto-repeat, and
// forwards minute strobes / minute carry to the counters in run mode.
//
// state   | meaning
// IDLE    | no button active; waits for a single press, toggles field on sel
// HOLD    | first pulse sent, counting ticks until auto-repeat starts
// REPEAT  | auto-repeating every REPEAT_TICKS ticks
// LOCKOUT | both buttons seen; silent until both are released
module time_adjust_ctrl
    import time_adjust_ctrl_pkg::*;
#(
    parameter int HOLD_TICKS   = 50,
    parameter int REPEAT_TICKS = 10
) (
    input logic                clk,
    input logic                rst,
    time_adjust_ctrl_if.master bus
);
    localparam int CW = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_TICKS - 1);

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            dir_q, dir_n;
    logic            field_q, field_n;
    logic            cmd, cmd_dir;
    logic            active_btn, other_btn;
    logic [CW-1:0]   tc;
    logic            sel_rise, carry_rise;

    time_adjust_ctrl_edge_pulse u_sel_edge (
        .clk (clk), .rst (rst), .din (bus.btn_sel), .rise (sel_rise)
    );

    time_adjust_ctrl_edge_pulse u_carry_edge (
        .clk (clk), .rst (rst), .din (bus.min_carry), .rise (carry_rise)
    );

    assign active_btn = dir_q ? bus.btn_up   : bus.btn_down;
    assign other_btn  = dir_q ? bus.btn_down : bus.btn_up;
    assign tc         = (state_q == ST_HOLD) ? HOLD_TC : REP_TC;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        dir_n   = dir_q;
        field_n = field_q;
        cmd     = 1'b0;
        cmd_dir = dir_q;
        if (!bus.adj_mode) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_rise)
                        field_n = ~field_q;
                    if (bus.btn_up ^ bus.btn_down) begin
                        cmd     = 1'b1;
                        cmd_dir = bus.btn_up;
                        dir_n   = bus.btn_up;
                        cnt_n   = '0;
                        state_n = ST_HOLD;
                    end else if (bus.btn_up && bus.btn_down) begin
                        state_n = ST_LOCKOUT;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    if (other_btn) begin
                        state_n = ST_LOCKOUT;
                    end else if (!active_btn) begin
                        state_n = ST_IDLE;
                    end else if (bus.tick) begin
                        if (cnt_q == tc) begin
                            cmd     = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_REPEAT;
                        end else if (cnt_q != '1) begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (!bus.btn_up && !bus.btn_down)
                        state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            dir_q          <= 1'b1;
            field_q        <= FIELD_MIN;
            bus.min_en     <= 1'b0;
            bus.hr_en      <= 1'b0;
            bus.min_updown <= 1'b1;
            bus.hr_updown  <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            dir_q   <= dir_n;
            field_q <= field_n;
            if (bus.adj_mode) begin
                // carry edges are dropped here so minute adjustment never moves hours
                bus.min_en <= cmd && (field_q == FIELD_MIN);
                bus.hr_en  <= cmd && (field_q == FIELD_HR);
                if (cmd && (field_q == FIELD_MIN))
                    bus.min_updown <= cmd_dir;
                if (cmd && (field_q == FIELD_HR))
                    bus.hr_updown <= cmd_dir;
            end else begin
                bus.min_en     <= bus.minute_tick;
                bus.hr_en      <= carry_rise;
                bus.min_updown <= 1'b1;
                bus.hr_updown  <= 1'b1;
            end
        end
    end

    assign bus.field = field_q;
endmodule

// File: doc/time_adjust_ctrl.md
# time_adjust_ctrl

Command generator for the minute and hour counters of the alarm clock. Turns debounced push-buttons into single-cycle `en` pulses and an `updown` direction, with press-and-hold auto-repeat. In run mode it forwards the once-per-minute strobe to the minutes counter and converts the minutes counter's level-held carry into a one-cycle hour enable. Sits between the button debouncers / seconds stage and the `minutesCounter` / hours counter pair.

## Interface
- `HOLD_TICKS`, default 50: `tick` strobes a button must stay held before auto-repeat starts.
- `REPEAT_TICKS`, default 10: `tick` strobes between auto-repeat pulses.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tick`  in  1  one-cycle timing strobe (100 Hz nominal).
- `minute_tick`  in  1  one-cycle strobe from the seconds stage; used only in run mode.
- `adj_mode`  in  1  1 = adjust mode, 0 = run mode; level input.
- `btn_up`, `btn_down`, `btn_sel`  in  1 each  debounced, synchronised, active-high levels.
- `min_carry`  in  1  `hourEnabler` from the minutes counter; level, held until the next minute enable.
- `min_en`  out  1  one-cycle enable to the minutes counter.
- `min_updown`  out  1  direction to the minutes counter; 1 = increment.
- `hr_en`  out  1  one-cycle enable to the hours counter.
- `hr_updown`  out  1  direction to the hours counter.
- `field`  out  1  selected field; 0 = minutes, 1 = hours.

## Operation
- **Reset values:**
  - `min_en`, `hr_en`, `field`: 0.
  - `min_updown`, `hr_updown`: 1.
  - FSM: IDLE. Tick counter: 0. `min_carry` history register: 0.
- **Run mode** (`adj_mode` = 0):
  - `min_en` = registered `minute_tick`; `min_updown` = 1.
  - `hr_en` = registered rising edge of `min_carry`; `hr_updown` = 1.
  - Buttons are ignored; FSM is forced to IDLE.
- **Adjust mode** (`adj_mode` = 1):
  - `minute_tick` is ignored.
  - `min_carry` edges never produce `hr_en`, because adjusting minutes must not move hours. The edge history register still updates every cycle.
  - Each command pulse goes to `min_en` if `field` = 0, else to `hr_en`.
  - The matching `updown` is 1 for up and 0 for down. The non-selected `updown` holds its value.
- **FSM states:**
  - IDLE:
    - Exactly one of `btn_up`/`btn_down` high: emit pulse, clear counter, go to HOLD.
    - Both high: go to LOCKOUT with no pulse.
    - Rising edge of `btn_sel`: toggle `field`.
  - HOLD:
    - Counter increments on `tick`.
    - Counter reaches `HOLD_TICKS`: emit pulse, clear counter, go to REPEAT.
  - REPEAT:
    - Counter increments on `tick`.
    - Counter reaches `REPEAT_TICKS`: emit pulse, clear counter, stay in REPEAT.
  - LOCKOUT: no pulses; go to IDLE when both buttons are low.
  - HOLD and REPEAT:
    - Active button released: go to IDLE.
    - Other button also pressed: go to LOCKOUT.
  - `btn_sel` is ignored outside IDLE.
- **Boundary rules:**
  - `adj_mode` falling edge mid-hold: go to IDLE next cycle with no pulse. `field` is retained.
  - Both buttons rising in the same cycle: LOCKOUT, no pulse.
  - Direction is latched at the first press. A held button never changes direction.
  - Counter width is `$clog2(max(HOLD_TICKS, REPEAT_TICKS)+1)`. The counter saturates and never wraps.
  - `rst` mid-operation: immediate return to reset values, including the carry history. A carry that is already high after reset produces no `hr_en`.

## Timing
- All outputs are registered.
- Latency is 1 cycle from:
  - the input condition (button edge, `minute_tick`, `min_carry` rise) to the `en` pulse;
  - the threshold-reaching `tick` to the repeat pulse.
- Each `en` pulse is exactly 1 cycle wide. `updown` is valid in the same cycle as its `en`.
- First repeat pulse: `HOLD_TICKS` ticks after the first pulse. Later pulses: every `REPEAT_TICKS` ticks.
- At most one of `min_en`/`hr_en` is high per cycle in adjust mode.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, HOLD, REPEAT, LOCKOUT);
  - the field encoding constants (FIELD_MIN = 0, FIELD_HR = 1).
- Natural sub-module: `edge_pulse`, a 1-bit registered rising-edge detector. Instantiate it for `btn_sel` and `min_carry`; button-press edges are handled inside the FSM.

## Test plan
- Run mode, 59 minutes counter wraps: one `min_carry` rise with the level held for 60 `minute_tick` periods -> exactly one `hr_en` pulse, 1 cycle wide, `hr_updown` = 1.
- Adjust, `field` = 0, tap `btn_up` for 3 cycles -> one `min_en` with `min_updown` = 1 one cycle after the press, no `hr_en`. Minutes go 59 -> 0 with `min_carry` rising -> still no `hr_en`.
- Adjust, `field` = 1, hold `btn_down` for 100 ticks with HOLD = 50, REPEAT = 10 -> pulses at tick 0, 50, 60, 70, 80, 90, 100, i.e. 7 `hr_en` pulses, `hr_updown` = 0.
- `btn_up` and `btn_down` rise in the same cycle -> no pulses. Release `btn_up` only -> still none until both are released. Then pressing `btn_down` -> one pulse.
- Hold `btn_up` 30 ticks, drop `adj_mode` -> no further `min_en` except run-mode forwarding. Assert `rst` mid-REPEAT -> all outputs at reset values in the same cycle, `field` = 0.
